pipe_fixed_point_acc: RTL

Pipelined, streaming fixed-point accumulator for framed sample streams. It sums or subtracts signed two's-complement samples over a frame delimited by `i_first` and `i_last`. The sum is kept in a wide, saturating accumulator. Each frame result is re-quantised to the output format with optional rounding and saturation. It extends the combinational two-operand fixed-point adder with a registered datapath, framing, an add/subtract mode, and per-frame overflow reporting. It is used for dot-product tails, moving sums and DC estimators.

---
 rtl/pipe_fixed_point_acc.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_fixed_point_acc.sv
// Streaming framed fixed-point accumulator: exact input alignment, saturating
// accumulation, and per-frame re-quantisation with rounding and overflow flags.
module pipe_fixed_point_acc #(
    parameter int unsigned WII   = 8,
    parameter int unsigned WIF   = 8,
    parameter int unsigned WAI   = 16,
    parameter int unsigned WAF   = 8,
    parameter int unsigned WOI   = 8,
    parameter int unsigned WOF   = 4,
    parameter bit          ROOF  = 1'b1,
    parameter bit          ROUND = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_en,
    input  logic                   i_first,
    input  logic                   i_last,
    input  logic                   i_sub,
    input  logic [WII+WIF-1:0]     in,
    output logic                   o_en,
    output logic [WOI+WOF-1:0]     out,
    output logic                   upflow,
    output logic                   downflow,
    output logic                   o_accsat
);
    localparam int unsigned WA = WAI + WAF;
    localparam int unsigned SW = WA + 1;
    localparam int unsigned WO = WOI + WOF;
    localparam int unsigned QW = WAI + WOF + 1;
    localparam int unsigned EW = (QW > WO) ? QW : WO;

    localparam logic [WA-1:0] ACC_MIN = WA'(1) << (WA - 1);
    localparam logic [WA-1:0] ACC_MAX = ~ACC_MIN;
    localparam logic [WO-1:0] OUT_MIN = WO'(1) << (WO - 1);
    localparam logic [WO-1:0] OUT_MAX = ~OUT_MIN;

    logic                 r1_v;
    logic                 r1_first;
    logic                 r1_last;
    logic                 r1_sub;
    logic signed [WA-1:0] r1_x;
    logic signed [WA-1:0] w_x_al;

    logic signed [WA-1:0] r_acc;
    logic                 r_fsat;
    logic                 r2_v;
    logic signed [WA-1:0] r2_sum;
    logic                 r2_sat;

    logic signed [SW-1:0] w_base;
    logic signed [SW-1:0] w_sum;
    logic                 w_ovf;
    logic signed [WA-1:0] w_clamped;
    logic                 w_fsat_nx;

    logic signed [QW-1:0] w_q;
    logic                 r3_v;
    logic signed [QW-1:0] r3_q;
    logic                 r3_sat;

    logic signed [EW-1:0] w_qe;
    logic [EW-WO:0]       w_hi;
    logic                 w_up;
    logic                 w_dn;
    logic [WO-1:0]        w_oval;

    logic                 r_oen;
    logic [WO-1:0]        r_out;
    logic                 r_up;
    logic                 r_dn;
    logic                 r_accsat;

    // Sign-extend the integer part and zero-pad the fraction: always exact
    assign w_x_al = WA'(signed'(in)) <<< (WAF - WIF);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r1_v     <= 1'b0;
            r1_first <= 1'b0;
            r1_last  <= 1'b0;
            r1_sub   <= 1'b0;
            r1_x     <= '0;
        end else begin
            r1_v <= i_en;
            if (i_en) begin
                r1_first <= i_first;
                r1_last  <= i_last;
                r1_sub   <= i_sub;
                r1_x     <= w_x_al;
            end
        end
    end

    // One guard bit makes base +/- x exact before clamping to the accumulator range
    always_comb begin
        w_base = SW'(r_acc);
        if (r1_first) begin
            w_base = '0;
        end
        if (r1_sub) begin
            w_sum = w_base - SW'(r1_x);
        end else begin
            w_sum = w_base + SW'(r1_x);
        end
        w_ovf     = w_sum[SW-1] ^ w_sum[SW-2];
        w_clamped = w_sum[SW-2:0];
        if (w_ovf) begin
            w_clamped = w_sum[SW-1] ? ACC_MIN : ACC_MAX;
        end
        w_fsat_nx = w_ovf | (r_fsat & ~r1_first);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc  <= '0;
            r_fsat <= 1'b0;
            r2_v   <= 1'b0;
            r2_sum <= '0;
            r2_sat <= 1'b0;
        end else begin
            r2_v <= r1_v & r1_last;
            if (r1_v) begin
                r_acc  <= w_clamped;
                r_fsat <= w_fsat_nx;
            end
            if (r1_v && r1_last) begin
                r2_sum <= w_clamped;
                r2_sat <= w_fsat_nx;
            end
        end
    end

    // Fraction re-quantisation; the extra top bit absorbs the rounding carry
    generate
        if (WOF >= WAF) begin : g_pad
            assign w_q = QW'(r2_sum) <<< (WOF - WAF);
        end else begin : g_drop
            localparam int unsigned SH = WAF - WOF;
            localparam logic signed [SW-1:0] HALF = ROUND ? (SW'(1) <<< (SH - 1)) : '0;
            assign w_q = QW'((SW'(r2_sum) + HALF) >>> SH);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r3_v   <= 1'b0;
            r3_q   <= '0;
            r3_sat <= 1'b0;
        end else begin
            r3_v <= r2_v;
            if (r2_v) begin
                r3_q   <= w_q;
                r3_sat <= r2_sat;
            end
        end
    end

    // In range iff every bit above the output sign bit matches it
    always_comb begin
        w_qe   = EW'(r3_q);
        w_hi   = w_qe[EW-1:WO-1];
        w_up   = 1'b0;
        w_dn   = 1'b0;
        if (!((&w_hi) || !(|w_hi))) begin
            w_up = ~w_hi[EW-WO];
            w_dn = w_hi[EW-WO];
        end
        w_oval = w_qe[WO-1:0];
        if (ROOF && w_up) begin
            w_oval = OUT_MAX;
        end else if (ROOF && w_dn) begin
            w_oval = OUT_MIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_oen    <= 1'b0;
            r_out    <= '0;
            r_up     <= 1'b0;
            r_dn     <= 1'b0;
            r_accsat <= 1'b0;
        end else begin
            r_oen <= r3_v;
            if (r3_v) begin
                r_out    <= w_oval;
                r_up     <= w_up;
                r_dn     <= w_dn;
                r_accsat <= r3_sat;
            end
        end
    end

    assign o_en     = r_oen;
    assign out      = r_out;
    assign upflow   = r_up;
    assign downflow = r_dn;
    assign o_accsat = r_accsat;

endmodule
